// File: rtl/ifq_pkg.sv
// Shared fetch/decode definitions: machine width and the canonical NOP encoding.
package ifq_pkg;

    localparam int XLEN = 64;

    // addi x0, x0, 0; also used by decode for bubble injection
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifq.sv
// Instruction fetch queue: circular buffer between fetch and decode with
// first-word-fall-through head, NOP on empty, and flush priority over all events.
module ifq
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [PC_W-1:0]          if_pc,
    input  logic [31:0]              if_instr,
    input  logic                     if_page_fault,
    input  logic                     if_bp_taken,
    input  logic [PC_W-1:0]          if_bp_target,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [PC_W-1:0]          dec_pc,
    output logic [31:0]              dec_instr,
    output logic                     dec_page_fault,
    output logic                     dec_bp_taken,
    output logic [PC_W-1:0]          dec_bp_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;

    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            pf_mem    [DEPTH];
    logic            bpt_mem   [DEPTH];
    logic [PC_W-1:0] tgt_mem   [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

    // if_ready depends only on registered pointers, never on dec_ready.
    assign if_ready  = !full;
    assign dec_valid = !empty;
    assign count     = wr_ptr_q - rd_ptr_q;

    assign push = if_valid && if_ready && !flush;
    assign pop  = dec_valid && dec_ready && !flush;

    // Pointer next-state: flush returns both pointers to zero and dominates push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage, written at the tail on an accepted push; contents are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q[AW-1:0]]    <= if_pc;
            instr_mem[wr_ptr_q[AW-1:0]] <= if_instr;
            pf_mem[wr_ptr_q[AW-1:0]]    <= if_page_fault;
            bpt_mem[wr_ptr_q[AW-1:0]]   <= if_bp_taken;
            tgt_mem[wr_ptr_q[AW-1:0]]   <= if_bp_target;
        end
    end

    // Head mux: oldest entry when occupied, otherwise a clean NOP bubble.
    always_comb begin
        dec_pc         = '0;
        dec_instr      = NOP_INSTR;
        dec_page_fault = 1'b0;
        dec_bp_taken   = 1'b0;
        dec_bp_target  = '0;
        if (!empty) begin
            dec_pc         = pc_mem[rd_ptr_q[AW-1:0]];
            dec_instr      = instr_mem[rd_ptr_q[AW-1:0]];
            dec_page_fault = pf_mem[rd_ptr_q[AW-1:0]];
            dec_bp_taken   = bpt_mem[rd_ptr_q[AW-1:0]];
            dec_bp_target  = tgt_mem[rd_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: scoreboard queue of expected entries, one task per scenario.
module tb_ifq;

    localparam int DEPTH = 4;
    localparam int PC_W  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            pf;
        logic            bt;
        logic [PC_W-1:0] tgt;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            if_valid = 1'b0;
    logic            if_ready;
    logic [PC_W-1:0] if_pc = '0;
    logic [31:0]     if_instr = '0;
    logic            if_page_fault = 1'b0;
    logic            if_bp_taken = 1'b0;
    logic [PC_W-1:0] if_bp_target = '0;
    logic            dec_valid;
    logic            dec_ready = 1'b0;
    logic [PC_W-1:0] dec_pc;
    logic [31:0]     dec_instr;
    logic            dec_page_fault;
    logic            dec_bp_taken;
    logic [PC_W-1:0] dec_bp_target;
    logic [2:0]      count;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;
    int pushes = 0;

    ifq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_page_fault(if_page_fault), .if_bp_taken(if_bp_taken), .if_bp_target(if_bp_target),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_page_fault(dec_page_fault), .dec_bp_taken(dec_bp_taken),
        .dec_bp_target(dec_bp_target), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [PC_W-1:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    // One cycle: apply inputs after a falling edge, check state against the model,
    // score any pop, update the model, then advance to the next falling edge.
    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic pf,
                        input logic bt, input logic [PC_W-1:0] tg,
                        input logic rdy, input logic fl);
        int  sz;
        bit  do_push;
        entry_t e;
        if_valid = v; if_pc = pc; if_instr = instr_of(pc); if_page_fault = pf;
        if_bp_taken = bt; if_bp_target = tg; dec_ready = rdy; flush = fl;
        #1;
        sz = sb.size();
        checks++;
        if (int'(count) !== sz) begin
            errors++; $display("FAIL count: got %0d want %0d", count, sz);
        end
        checks++;
        if (if_ready !== (sz < DEPTH)) begin
            errors++; $display("FAIL if_ready: got %b want %b", if_ready, sz < DEPTH);
        end
        checks++;
        if (dec_valid !== (sz != 0)) begin
            errors++; $display("FAIL dec_valid: got %b want %b", dec_valid, sz != 0);
        end
        if (sz == 0) begin
            checks++;
            if (dec_instr !== NOP || dec_pc !== '0 || dec_page_fault !== 1'b0 ||
                dec_bp_taken !== 1'b0 || dec_bp_target !== '0) begin
                errors++;
                $display("FAIL empty_head: got instr=%h pc=%h pf=%b bt=%b tgt=%h want instr=%h rest 0",
                         dec_instr, dec_pc, dec_page_fault, dec_bp_taken, dec_bp_target, NOP);
            end
        end else begin
            e = sb[0];
            checks++;
            if (dec_pc !== e.pc || dec_instr !== e.instr || dec_page_fault !== e.pf ||
                dec_bp_taken !== e.bt || dec_bp_target !== e.tgt) begin
                errors++;
                $display("FAIL head: got pc=%h instr=%h pf=%b bt=%b tgt=%h want pc=%h instr=%h pf=%b bt=%b tgt=%h",
                         dec_pc, dec_instr, dec_page_fault, dec_bp_taken, dec_bp_target,
                         e.pc, e.instr, e.pf, e.bt, e.tgt);
            end
        end
        do_push = v && (sz < DEPTH) && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (rdy && sz != 0) void'(sb.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = instr_of(pc); e.pf = pf; e.bt = bt; e.tgt = tg;
                sb.push_back(e);
                pushes++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic push_pc(input logic [PC_W-1:0] pc, input logic rdy);
        step(1'b1, pc, 1'b0, 1'b0, pc + 64'd4, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) push_pc(64'h1000 + 64'(4 * i), 1'b0);
        push_pc(64'h1010, 1'b0);
        idle(1'b0);
        drain();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) push_pc(64'h5000 + 64'(4 * i), 1'b1);
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_pc(64'h1100 + 64'(4 * i), 1'b0);
        step(1'b1, 64'h2000, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        push_pc(64'h3000, 1'b0);
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_page_fault();
        step(1'b1, 64'h8000_0000, 1'b1, 1'b1, 64'h8000_0040, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) push_pc(64'h6000 + 64'(4 * i), 1'b0);
        push_pc(64'h6100, 1'b1);
        push_pc(64'h6100, 1'b0);
        idle(1'b0);
        drain();
    endtask

    task automatic test_async_reset();
        push_pc(64'h7000, 1'b0);
        push_pc(64'h7004, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got dec_valid=%b count=%0d want 0 0", dec_valid, count);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_pc(64'h4000, 1'b0);
        idle(1'b1);
        idle(1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush();
        test_page_fault();
        test_full_pop();
        test_async_reset();
        checks++;
        if (pushes < 4 * DEPTH + 4) begin
            errors++; $display("FAIL wrap_coverage: got %0d pushes want >= %0d", pushes, 4 * DEPTH + 4);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
